mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
Game sequencer for the whack-a-mole playfield. It picks a pseudo-random column, raises a mole there for a fixed number of game ticks, judges player presses, and keeps score and miss counts. Its col_sel output drives the 2-bit column decoder directly. Outside UP/HIT it drives code 3, which the decoder maps to all-columns-off.

Parameters:
UP_TICKS, 8, ticks a mole stays up before counting as a miss (1..255)
GAP_TICKS, 4, ticks with no mole between moles (1..255)
MAX_MISSES, 5, miss count that ends the game (1..15)
LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
start  input  1  level; starts or restarts the game from IDLE or OVER
tick  input  1  one-clk pulse, game time base from the rate divider
hit_btn  input  3  one-hot player buttons, bit2=col1, bit1=col2, bit0=col3, synchronous, active-high
col_sel  output  2  column code to the decoder: 0..2 = column 1..3, 3 = none
mole_up  output  1  high in UP
hit_flash  output  1  high in HIT
score  output  8  hit count, saturates at 255
misses  output  4  miss count
game_over  output  1  high in OVER

Behaviour:
- One clock domain. Reset is synchronous, active-low, sampled on the clk rising edge. Synchronous reset is decided.
- Reset values: state=IDLE, col_sel=3, mole_up=0, hit_flash=0, score=0, misses=0, game_over=0, lfsr=LFSR_SEED, tick_cnt=0, btn_prev=3'b000.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It shifts every clk, regardless of state.
- Column pick: c = lfsr[1:0] sampled on the clk of entry to UP; c=3 maps to 1.
- Press detect: press = hit_btn & ~btn_prev, with btn_prev registered every clk. Only rising edges count, so a held button never re-triggers.
- Target mask for column c: {c==0, c==1, c==2}, which matches the decoder one-hot order.
- States:
  - IDLE: col_sel=3. When start=1, clear score and misses, load tick_cnt=GAP_TICKS, go to GAP next clk.
  - GAP: col_sel=3. Each tick decrements tick_cnt. On the tick where tick_cnt==1, pick a column, load tick_cnt=UP_TICKS, go to UP.
  - UP: col_sel=c, mole_up=1. Evaluate in this priority order:
    1. (press & target) != 0: score+1 (saturating), go to HIT, tick_cnt=1.
    2. Else, on the tick where tick_cnt==1: misses+1; if the new misses equals MAX_MISSES go to OVER, else go to GAP with tick_cnt=GAP_TICKS.
    3. Else, on a tick: decrement tick_cnt.
    - A wrong-column press is ignored: no score change, no miss.
    - Correct press and expiring tick in the same clk: the hit wins.
    - Multiple buttons pressed together that include the target count as a hit.
  - HIT: col_sel=c, hit_flash=1. The next tick goes to GAP with tick_cnt=GAP_TICKS.
  - OVER: col_sel=3, game_over=1. Score and misses hold. When start=1, clear counters and go to GAP with tick_cnt=GAP_TICKS.
- Outputs are Moore, registered, and change on the clk after the state transition. col_sel updates in the same clk as the state register.
- Latency: correct press edge in clk N gives score, state and hit_flash updated at clk N+1.
- start is ignored in GAP, UP and HIT.
- tick asserted for multiple consecutive clks counts once per clk.
- resetn low mid-game returns to IDLE next clk with all outputs at reset values, regardless of tick or press.
- score at 255 plus a hit stays at 255 and the state still goes to HIT.
- misses never exceed MAX_MISSES.

Test Plan:
1. Reset and idle. Params UP=4, GAP=2, MAX=3; tick every clk; resetn low 2 clks then high, start=0 for 10 clks -> col_sel=3, all other outputs 0, state stays IDLE.
2. Correct hit. Pulse start; wait for mole_up; press the button matching col_sel for 1 clk -> next clk score=1, hit_flash=1; 1 tick later col_sel=3. A held button gives no second increment.
3. Wrong press and timeouts. Press a non-target button in every UP -> score stays 0, misses goes 1,2,3. After the 3rd timeout, game_over=1 and col_sel=3; the whole sequence takes exactly 3*(2+4) ticks after start.
4. Simultaneous event. Correct press in the same clk as the expiring tick (tick_cnt==1) -> score+1, misses unchanged, state HIT.
5. Saturation and restart. Force 256 hits -> score=255. Reach OVER, then pulse start -> score=0, misses=0, GAP entered, first mole after 2 ticks.
6. Reset mid-UP. Drop resetn while mole_up=1 -> next clk all outputs at reset values, lfsr=8'hA5. Repeating the run reproduces an identical col_sel sequence.

Source files
------------

// File: rtl/mole_scheduler_if.sv
// Player/game-side signal bundle for the whack-a-mole sequencer.
// master drives game controls and buttons; slave is the scheduler.
interface mole_scheduler_if;
  logic       start;
  logic       tick;
  logic [2:0] hit_btn;
  logic [1:0] col_sel;
  logic       mole_up;
  logic       hit_flash;
  logic [7:0] score;
  logic [3:0] misses;
  logic       game_over;

  modport master (
    output start, tick, hit_btn,
    input  col_sel, mole_up, hit_flash, score, misses, game_over
  );

  modport slave (
    input  start, tick, hit_btn,
    output col_sel, mole_up, hit_flash, score, misses, game_over
  );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: LFSR column pick, timed mole, press judging,
// score/miss bookkeeping. All outputs registered alongside the state.
module mole_scheduler #(
  parameter int unsigned UP_TICKS   = 8,
  parameter int unsigned GAP_TICKS  = 4,
  parameter int unsigned MAX_MISSES = 5,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic clk,
  input  logic resetn,
  mole_scheduler_if.slave io
);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_UP, S_HIT, S_OVER} state_t;

  localparam logic [7:0] UP_L  = 8'(UP_TICKS);
  localparam logic [7:0] GAP_L = 8'(GAP_TICKS);
  localparam logic [3:0] MAX_L = 4'(MAX_MISSES);

  state_t     r_state;
  logic [7:0] r_tick_cnt;
  logic [1:0] r_col;
  logic [7:0] r_score;
  logic [3:0] r_misses;
  logic [7:0] r_lfsr;
  logic [2:0] r_btn_prev;
  logic [1:0] r_col_sel;
  logic       r_mole_up;
  logic       r_hit_flash;
  logic       r_game_over;

  state_t     w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic [1:0] w_col_nxt;
  logic [7:0] w_score_nxt;
  logic [3:0] w_misses_nxt;
  logic [3:0] w_misses_inc;
  logic [2:0] w_press;
  logic [2:0] w_target;
  logic [1:0] w_pick;
  logic       w_fb;

  assign w_fb         = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_pick       = (r_lfsr[1:0] == 2'd3) ? 2'd1 : r_lfsr[1:0];
  assign w_press      = io.hit_btn & ~r_btn_prev;
  assign w_target     = {r_col == 2'd0, r_col == 2'd1, r_col == 2'd2};
  assign w_misses_inc = r_misses + 4'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_tick_cnt;
    w_col_nxt    = r_col;
    w_score_nxt  = r_score;
    w_misses_nxt = r_misses;
    unique case (r_state)
      S_IDLE, S_OVER: begin
        if (io.start) begin
          w_score_nxt  = '0;
          w_misses_nxt = '0;
          w_cnt_nxt    = GAP_L;
          w_state_nxt  = S_GAP;
        end
      end
      S_GAP: begin
        if (io.tick) begin
          if (r_tick_cnt == 8'd1) begin
            w_col_nxt   = w_pick;
            w_cnt_nxt   = UP_L;
            w_state_nxt = S_UP;
          end else begin
            w_cnt_nxt = r_tick_cnt - 8'd1;
          end
        end
      end
      S_UP: begin
        // A correct press outranks the expiring tick in the same clock.
        if ((w_press & w_target) != '0) begin
          w_score_nxt = (r_score == '1) ? r_score : r_score + 8'd1;
          w_cnt_nxt   = 8'd1;
          w_state_nxt = S_HIT;
        end else if (io.tick) begin
          if (r_tick_cnt == 8'd1) begin
            w_misses_nxt = w_misses_inc;
            if (w_misses_inc == MAX_L) begin
              w_state_nxt = S_OVER;
            end else begin
              w_cnt_nxt   = GAP_L;
              w_state_nxt = S_GAP;
            end
          end else begin
            w_cnt_nxt = r_tick_cnt - 8'd1;
          end
        end
      end
      S_HIT: begin
        if (io.tick) begin
          w_cnt_nxt   = GAP_L;
          w_state_nxt = S_GAP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_col       <= '0;
      r_score     <= '0;
      r_misses    <= '0;
      r_lfsr      <= LFSR_SEED;
      r_btn_prev  <= '0;
      r_col_sel   <= 2'd3;
      r_mole_up   <= 1'b0;
      r_hit_flash <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_cnt  <= w_cnt_nxt;
      r_col       <= w_col_nxt;
      r_score     <= w_score_nxt;
      r_misses    <= w_misses_nxt;
      r_lfsr      <= {r_lfsr[6:0], w_fb};
      r_btn_prev  <= io.hit_btn;
      r_col_sel   <= (w_state_nxt == S_UP || w_state_nxt == S_HIT) ? w_col_nxt : 2'd3;
      r_mole_up   <= (w_state_nxt == S_UP);
      r_hit_flash <= (w_state_nxt == S_HIT);
      r_game_over <= (w_state_nxt == S_OVER);
    end
  end

  assign io.col_sel   = r_col_sel;
  assign io.mole_up   = r_mole_up;
  assign io.hit_flash = r_hit_flash;
  assign io.score     = r_score;
  assign io.misses    = r_misses;
  assign io.game_over = r_game_over;

endmodule

// File: tb/tb_mole_scheduler.sv
// Randomized bench for mole_scheduler: game-rule reference model feeds an
// expectation queue that a negedge monitor drains against the DUT outputs.
module tb_mole_scheduler;
  localparam int UP   = 4;
  localparam int GAP  = 2;
  localparam int MAXM = 3;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mole_scheduler_if io();

  mole_scheduler #(
    .UP_TICKS(UP), .GAP_TICKS(GAP), .MAX_MISSES(MAXM), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .resetn(resetn), .io(io)
  );

  typedef struct packed {
    logic [1:0] col;
    logic       up;
    logic       hf;
    logic [7:0] score;
    logic [3:0] miss;
    logic       go;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  // Reference game state, described in terms of the rules
  string      m_phase = "IDLE";
  int         m_cnt   = 0;
  int         m_c     = 0;
  int         m_score = 0;
  int         m_miss  = 0;
  logic [7:0] m_lfsr  = 8'hA5;
  logic [2:0] m_prev  = 3'b000;

  function automatic obs_t expect_now();
    obs_t o;
    o.col   = (m_phase == "UP" || m_phase == "HIT") ? 2'(m_c) : 2'd3;
    o.up    = (m_phase == "UP");
    o.hf    = (m_phase == "HIT");
    o.score = 8'(m_score);
    o.miss  = 4'(m_miss);
    o.go    = (m_phase == "OVER");
    return o;
  endfunction

  function automatic logic [2:0] target();
    return 3'b100 >> m_c;
  endfunction

  task automatic model_step(input logic s, input logic t, input logic [2:0] b, input logic r);
    logic [7:0] nl;
    logic [2:0] press;
    int         pick;
    nl = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    if (!r) begin
      m_phase = "IDLE"; m_cnt = 0; m_score = 0; m_miss = 0;
      m_prev = 3'b000; m_lfsr = 8'hA5;
    end else begin
      press  = b & ~m_prev;
      m_prev = b;
      if (m_phase == "IDLE" || m_phase == "OVER") begin
        if (s) begin m_score = 0; m_miss = 0; m_cnt = GAP; m_phase = "GAP"; end
      end else if (m_phase == "GAP") begin
        if (t) begin
          if (m_cnt == 1) begin
            pick = int'(m_lfsr % 4);
            m_c = (pick == 3) ? 1 : pick;
            m_cnt = UP; m_phase = "UP";
          end else m_cnt--;
        end
      end else if (m_phase == "UP") begin
        if ((press & target()) != 3'b000) begin
          if (m_score < 255) m_score++;
          m_cnt = 1; m_phase = "HIT";
        end else if (t) begin
          if (m_cnt == 1) begin
            m_miss++;
            if (m_miss == MAXM) m_phase = "OVER";
            else begin m_cnt = GAP; m_phase = "GAP"; end
          end else m_cnt--;
        end
      end else if (m_phase == "HIT") begin
        if (t) begin m_cnt = GAP; m_phase = "GAP"; end
      end
      m_lfsr = nl;
    end
  endtask

  task automatic step(input logic s, input logic t, input logic [2:0] b, input logic r);
    io.start = s; io.tick = t; io.hit_btn = b; resetn = r;
    model_step(s, t, b, r);
    exp_q.push_back(expect_now());
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] wrong_btn();
    logic [2:0] b;
    b = 3'b001 << $urandom_range(0, 2);
    if (b == target()) b = (target() == 3'b001) ? 3'b010 : 3'b001;
    return b;
  endfunction

  // 0 none, 1 hit seeker, 2 wrong presses, 3 hit on expiring tick, 4 random
  function automatic logic [2:0] pick_btn(input int mode, input logic t);
    logic [2:0] b;
    b = 3'b000;
    case (mode)
      1: if (m_phase == "UP")
           b = ((m_prev & target()) != 3'b000) ? 3'b000
             : (target() | (($urandom_range(0, 3) == 0) ? wrong_btn() : 3'b000));
         else
           b = ($urandom_range(0, 1) == 1) ? m_prev : 3'b000;
      2: if (m_phase == "UP") b = wrong_btn();
      3: if (m_phase == "UP" && t && m_cnt == 1) b = target();
      4: case ($urandom_range(0, 2))
           0: b = 3'($urandom_range(0, 7));
           1: b = m_prev;
           default: b = 3'b000;
         endcase
      default: b = 3'b000;
    endcase
    return b;
  endfunction

  task automatic play(input int mode, input int n, input bit rand_tick);
    logic t;
    for (int i = 0; i < n; i++) begin
      t = rand_tick ? logic'($urandom_range(0, 1)) : 1'b1;
      step(1'b0, t, pick_btn(mode, t), 1'b1);
    end
  endtask

  // Monitor: one registered observation per clock, compared away from the edge
  always @(negedge clk) begin
    obs_t e, g;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = {io.col_sel, io.mole_up, io.hit_flash, io.score, io.misses, io.game_over};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got col=%0d up=%b hf=%b score=%0d miss=%0d go=%b, want col=%0d up=%b hf=%b score=%0d miss=%0d go=%b",
                 $time, g.col, g.up, g.hf, g.score, g.miss, g.go,
                 e.col, e.up, e.hf, e.score, e.miss, e.go);
      end
    end
  end

  initial begin
    int n;
    io.start = 0; io.tick = 0; io.hit_btn = '0; resetn = 0;

    // Reset then a quiet IDLE with ticks running
    step(0, 1, 3'b000, 0);
    step(0, 1, 3'b000, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 3'b000, 1);

    // Wrong presses only: three timeouts end the game after 3*(GAP+UP) ticks
    step(1, 1, 3'b000, 1);
    n = 0;
    while (!io.game_over && n < 100) begin
      step(0, 1, pick_btn(2, 1'b1), 1'b1);
      n++;
    end
    checks++;
    if (n != 3 * (GAP + UP)) begin
      errors++;
      $display("FAIL over_latency: got %0d ticks, want %0d", n, 3 * (GAP + UP));
    end

    // Restart from OVER and chase hits well past score saturation
    step(1, 1, 3'b000, 1);
    play(1, 1500, 1'b0);
    checks++;
    if (io.score !== 8'd255) begin
      errors++;
      $display("FAIL score_saturate: got %0d, want 255", io.score);
    end

    // Lose the game, restart, then hit only on the expiring tick
    n = 0;
    while (m_phase != "OVER" && n < 2000) begin
      play(2, 1, 1'b1);
      n++;
    end
    step(1, 1, 3'b000, 1);
    play(3, 300, 1'b1);

    // Free-running random play including restarts
    for (int i = 0; i < 300; i++) begin
      logic t;
      t = logic'($urandom_range(0, 1));
      step(logic'($urandom_range(0, 7) == 0), t, pick_btn(4, t), 1'b1);
    end

    // Reset while a mole is up, then replay from the seed
    n = 0;
    while (m_phase != "UP" && n < 200) begin
      if (m_phase == "IDLE" || m_phase == "OVER") step(1, 1, 3'b000, 1);
      else play(0, 1, 1'b0);
      n++;
    end
    checks++;
    if (m_phase != "UP") begin
      errors++;
      $display("FAIL reach_up: got no mole within %0d steps, want one", n);
    end
    step(0, 1, 3'b111, 0);
    step(1, 1, 3'b000, 1);
    play(1, 200, 1'b1);
    play(4, 200, 1'b1);

    @(negedge clk);
    #2;
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
